program_loader: RTL and testbench



---
 rtl/program_loader_pkg.sv | 20 ++
 rtl/program_loader_if.sv | 30 +++
 rtl/program_loader_word_assembler.sv | 40 ++++
 rtl/program_loader.sv | 129 ++++++++++++
 tb/tb_program_loader.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Optional checksum support is selected with PROGRAM_LOADER_CHECKSUM_EN.
package loader_pkg;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_W        = 8 * LEN_BYTES;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    LOAD,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave side is the loader; the master side is the byte source / memory.
interface program_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs accepted payload bytes little-endian into 32-bit words and emits a
// registered one-cycle word_valid pulse with the finished word.
module Word_Assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_accept,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [31:0] shift_q;

  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));

  // Shift bytes in from the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= 2'd0;
      shift_q    <= 32'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_accept) begin
        shift_q  <= {byte_data, shift_q[31:8]};
        byte_cnt <= byte_cnt + 2'd1;
        if (last_byte) begin
          word       <= {byte_data, shift_q[31:8]};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: fills instruction memory from a framed byte
// stream and holds the core in reset until the image is loaded.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_DEPTH_WORDS = 256
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus,
  output logic             core_resetn,
  output logic             done,
  output logic             error
);

  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(IMEM_DEPTH_WORDS);

  loader_state_t      state_q;
  loader_state_t      next_state;
  logic [COUNT_W-1:0] word_count;
  logic [COUNT_W-1:0] word_idx;
  logic [COUNT_W-1:0] count_now;
  logic               ready_dec;
  logic               accept;
  logic               load_accept;
  logic               last_byte;
  logic               last_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  // Never ready while reset is asserted, regardless of the stale state.
  assign bus.rx_ready = ready_dec & ~reset;
  assign accept       = bus.rx_valid & bus.rx_ready;
  assign load_accept  = accept & (state_q == LOAD);
  assign last_word    = (word_idx == word_count - COUNT_W'(1));

  Word_Assembler u_word_assembler (
    .clk         (clk),
    .reset       (reset),
    .byte_data   (bus.rx_data),
    .byte_accept (load_accept),
    .last_byte   (last_byte),
    .word_valid  (bus.imem_we),
    .word        (bus.imem_wdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= LEN_LO;
    else       state_q <= next_state;
  end

  // Next-state decode and the ready flag for the byte source.
  always_comb begin
    next_state = state_q;
    ready_dec  = 1'b0;
    count_now  = {bus.rx_data, word_count[7:0]};
    case (state_q)
      LEN_LO: begin
        ready_dec = 1'b1;
        if (accept) next_state = LEN_HI;
      end
      LEN_HI: begin
        ready_dec = 1'b1;
        if (accept) begin
          if (count_now == '0 || count_now > DEPTH_C) next_state = ERROR;
          else                                        next_state = LOAD;
        end
      end
      LOAD: begin
        ready_dec = 1'b1;
        if (accept && last_byte && last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          next_state = CSUM;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CSUM: begin
        ready_dec = 1'b1;
        if (accept) next_state = (bus.rx_data == csum_q) ? DONE : ERROR;
      end
`endif
      default: begin
        ready_dec  = 1'b0;
        next_state = state_q;
      end
    endcase
  end

  // Count capture, address counter, checksum and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_count    <= '0;
      word_idx      <= '0;
      bus.imem_addr <= 32'd0;
      core_resetn   <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q        <= 8'd0;
`endif
    end else begin
      if (accept && state_q == LEN_LO) word_count[7:0] <= bus.rx_data;
      if (accept && state_q == LEN_HI) begin
        word_count[COUNT_W-1:8] <= bus.rx_data;
        word_idx                <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_q                  <= 8'd0;
`endif
      end
      if (load_accept && last_byte) begin
        bus.imem_addr <= {{(30 - COUNT_W){1'b0}}, word_idx, 2'b00};
        word_idx      <= word_idx + COUNT_W'(1);
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (load_accept) csum_q <= csum_q ^ bus.rx_data;
`endif
      done        <= (next_state == DONE);
      core_resetn <= (next_state == DONE);
      error       <= (next_state == ERROR);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued by
// the stimulus and popped by an independent write monitor.
module tb_program_loader;

  logic clk = 1'b0;
  logic reset;
  logic core_resetn, done, error;

  program_loader_if bus ();

  program_loader #(.IMEM_DEPTH_WORDS(256)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .core_resetn (core_resetn),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } write_t;

  write_t      exp_q[$];
  int          checks      = 0;
  int          errors      = 0;
  int          writes_seen = 0;
  logic [31:0] last_addr   = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Write monitor: every imem_we must match the oldest queued expectation.
  always @(negedge clk) begin : write_monitor
    write_t e;
    if (bus.imem_we === 1'b1) begin
      writes_seen++;
      last_addr = bus.imem_addr;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected write: got addr 0x%08h data 0x%08h, expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        checkOutput("write addr", bus.imem_addr, e.addr);
        checkOutput("write data", bus.imem_wdata, e.data);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    checkOutput("rx_ready while sending", {31'd0, bus.rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic sendFrame(input logic [7:0] frame[$], input int gap_max);
    foreach (frame[i])
      applyStimulus(frame[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
  endtask

  task automatic doReset(input logic check_values);
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (check_values) begin
      checkOutput("reset imem_we",     {31'd0, bus.imem_we},  32'd0);
      checkOutput("reset imem_addr",   bus.imem_addr,         32'd0);
      checkOutput("reset imem_wdata",  bus.imem_wdata,        32'd0);
      checkOutput("reset core_resetn", {31'd0, core_resetn},  32'd0);
      checkOutput("reset done",        {31'd0, done},         32'd0);
      checkOutput("reset error",       {31'd0, error},        32'd0);
      checkOutput("reset rx_ready",    {31'd0, bus.rx_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rx_ready after reset", {31'd0, bus.rx_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkFinal(input string pfx, input logic exp_done, input logic exp_err,
                            input int wstart, input int exp_writes);
    @(negedge clk);
    checkOutput({pfx, " done"},        {31'd0, done},         {31'd0, exp_done});
    checkOutput({pfx, " error"},       {31'd0, error},        {31'd0, exp_err});
    checkOutput({pfx, " core_resetn"}, {31'd0, core_resetn},  {31'd0, exp_done});
    checkOutput({pfx, " rx_ready"},    {31'd0, bus.rx_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput({pfx, " write count"}, writes_seen - wstart, exp_writes);
    checkOutput({pfx, " pending writes"}, exp_q.size(), 32'd0);
  endtask

  task automatic pushNominalWrites();
    exp_q.push_back('{addr: 32'h0, data: 32'h00A00513});
    exp_q.push_back('{addr: 32'h4, data: 32'h00B00593});
  endtask

  initial begin
    logic [7:0]  nominal[$];
    logic [7:0]  bad[$];
    logic [7:0]  big[$];
    logic [7:0]  partial[$];
    logic [7:0]  csum;
    logic [31:0] w;
    int          wstart;

    nominal = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    bad = nominal;
    bad.push_back(8'h91);
    nominal.push_back(8'h90);
`endif
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(posedge clk);
    #1;

    $display("[TB] nominal frame");
    doReset(1'b1);
    wstart = writes_seen;
    pushNominalWrites();
    sendFrame(nominal, 0);
    checkFinal("nominal", 1'b1, 1'b0, wstart, 2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    $display("[TB] bad checksum");
    doReset(1'b0);
    wstart = writes_seen;
    pushNominalWrites();
    sendFrame(bad, 0);
    checkFinal("bad csum", 1'b0, 1'b1, wstart, 2);
`endif

    $display("[TB] zero count");
    doReset(1'b0);
    wstart = writes_seen;
    sendFrame('{8'h00, 8'h00}, 0);
    checkFinal("count 0", 1'b0, 1'b1, wstart, 0);

    $display("[TB] count 257");
    doReset(1'b0);
    wstart = writes_seen;
    sendFrame('{8'h01, 8'h01}, 0);
    checkFinal("count 257", 1'b0, 1'b1, wstart, 0);

    $display("[TB] count 256");
    doReset(1'b0);
    wstart = writes_seen;
    big  = '{8'h00, 8'h01};
    csum = 8'h00;
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'h5A, ~8'(i), 8'h13};
      exp_q.push_back('{addr: 32'(i * 4), data: w});
      for (int k = 0; k < 4; k++) begin
        big.push_back(w[8*k +: 8]);
        csum = csum ^ w[8*k +: 8];
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    big.push_back(csum);
`endif
    sendFrame(big, 0);
    checkFinal("count 256", 1'b1, 1'b0, wstart, 256);
    checkOutput("count 256 last addr", last_addr, 32'h3FC);

    $display("[TB] nominal frame with idle gaps");
    doReset(1'b0);
    wstart = writes_seen;
    pushNominalWrites();
    sendFrame(nominal, 5);
    checkFinal("gaps", 1'b1, 1'b0, wstart, 2);

    $display("[TB] reset mid-load");
    doReset(1'b0);
    wstart  = writes_seen;
    exp_q.push_back('{addr: 32'h0, data: 32'h00A00513});
    partial = nominal[0:7];
    sendFrame(partial, 0);
    doReset(1'b1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mid-load write count", writes_seen - wstart, 32'd1);
    checkOutput("mid-load done", {31'd0, done}, 32'd0);
    checkOutput("mid-load pending writes", exp_q.size(), 32'd0);
    wstart = writes_seen;
    pushNominalWrites();
    sendFrame(nominal, 0);
    checkFinal("reload", 1'b1, 1'b0, wstart, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
